// File: rtl/active_list_retire.sv
// active_list_retire: in-order retire and mispredict walk-back of renamed instructions.
// Define AL_PERF_CNT_EN to add saturating perf_commits/perf_squashed counters.
module active_list_retire #(
  parameter int DEPTH  = 32,
  parameter int TAG_W  = 5,
  parameter int PHYS_W = 6,
  parameter int ARCH_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic              alloc_uses_rw,
  input  logic [ARCH_W-1:0] alloc_arch_rd,
  input  logic [PHYS_W-1:0] alloc_new_phys,
  input  logic [PHYS_W-1:0] alloc_old_phys,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              wb_valid,
  input  logic [TAG_W-1:0]  wb_tag,
  input  logic              mispredict_valid,
  input  logic [TAG_W-1:0]  mispredict_tag,
  output logic              commit_valid,
  output logic [ARCH_W-1:0] commit_arch_rd,
  output logic [PHYS_W-1:0] commit_new_phys,
  output logic              free_valid,
  output logic [PHYS_W-1:0] free_phys,
  output logic              recover_valid,
  output logic [ARCH_W-1:0] recover_arch_rd,
  output logic [PHYS_W-1:0] recover_phys,
  output logic              recovering,
  output logic [TAG_W:0]    count,
  output logic              empty
`ifdef AL_PERF_CNT_EN
  ,
  output logic [31:0]       perf_commits,
  output logic [31:0]       perf_squashed
`endif
);
  typedef enum logic {RUN, RECOVER} state_t;
  state_t r_state, w_state_nx;
  logic [DEPTH-1:0]  r_valid, r_done, r_uses;
  logic [ARCH_W-1:0] r_arch [DEPTH];
  logic [PHYS_W-1:0] r_new [DEPTH];
  logic [PHYS_W-1:0] r_old [DEPTH];
  logic [TAG_W-1:0]  r_head, r_tail, r_stop;
  logic [TAG_W:0]    r_count;
  logic [TAG_W-1:0]  w_tail_inc, w_tail_dec, w_tail_acc, w_mp_stop;
  logic              w_accept, w_commit, w_mp, w_squash, w_commit_rw, w_squash_rw;
  assign alloc_ready = rst_n && r_state == RUN && !r_count[TAG_W];
  assign alloc_tag   = r_tail;
  assign recovering  = r_state == RECOVER;
  assign count       = r_count;
  assign empty       = r_count == '0;
  always_comb begin
    w_accept    = alloc_valid && alloc_ready;
    w_commit    = r_state == RUN && !mispredict_valid && r_valid[r_head] && r_done[r_head];
    w_mp        = r_state == RUN && mispredict_valid && r_valid[mispredict_tag];
    w_squash    = r_state == RECOVER;
    w_tail_inc  = r_tail + TAG_W'(1);
    w_tail_dec  = r_tail - TAG_W'(1);
    w_tail_acc  = w_accept ? w_tail_inc : r_tail;
    w_mp_stop   = mispredict_tag + TAG_W'(1);
    w_commit_rw = w_commit && r_uses[r_head];
    w_squash_rw = w_squash && r_uses[w_tail_dec];
  end
  // an entry accepted alongside the mispredict is younger than the branch, so it is walked back too
  always_comb begin
    w_state_nx = r_state;
    if (r_state == RUN) w_state_nx = (w_mp && w_tail_acc != w_mp_stop) ? RECOVER : RUN;
    else w_state_nx = (w_tail_dec == r_stop) ? RUN : RECOVER;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= RUN;
    else r_state <= w_state_nx;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid         <= '0;
      r_done          <= '0;
      r_head          <= '0;
      r_tail          <= '0;
      r_stop          <= '0;
      r_count         <= '0;
      commit_valid    <= 1'b0;
      commit_arch_rd  <= '0;
      commit_new_phys <= '0;
      free_valid      <= 1'b0;
      free_phys       <= '0;
      recover_valid   <= 1'b0;
      recover_arch_rd <= '0;
      recover_phys    <= '0;
`ifdef AL_PERF_CNT_EN
      perf_commits    <= '0;
      perf_squashed   <= '0;
`endif
    end else begin
      if (wb_valid && r_valid[wb_tag]) r_done[wb_tag] <= 1'b1;
      if (w_accept) begin
        r_valid[r_tail] <= 1'b1;
        r_done[r_tail]  <= 1'b0;
        r_uses[r_tail]  <= alloc_uses_rw;
        r_arch[r_tail]  <= alloc_arch_rd;
        r_new[r_tail]   <= alloc_new_phys;
        r_old[r_tail]   <= alloc_old_phys;
        r_tail          <= w_tail_inc;
      end
      if (w_commit) begin
        r_valid[r_head] <= 1'b0;
        r_done[r_head]  <= 1'b0;
        r_head          <= r_head + TAG_W'(1);
      end
      if (w_mp) r_stop <= w_mp_stop;
      if (w_squash) begin
        r_valid[w_tail_dec] <= 1'b0;
        r_done[w_tail_dec]  <= 1'b0;
        r_tail              <= w_tail_dec;
      end
      r_count         <= r_count + (TAG_W+1)'(w_accept) - (TAG_W+1)'(w_commit) - (TAG_W+1)'(w_squash);
      commit_valid    <= w_commit_rw;
      commit_arch_rd  <= w_commit_rw ? r_arch[r_head] : '0;
      commit_new_phys <= w_commit_rw ? r_new[r_head] : '0;
      recover_valid   <= w_squash_rw;
      recover_arch_rd <= w_squash_rw ? r_arch[w_tail_dec] : '0;
      recover_phys    <= w_squash_rw ? r_old[w_tail_dec] : '0;
      free_valid      <= w_commit_rw || w_squash_rw;
      free_phys       <= w_commit_rw ? r_old[r_head] : w_squash_rw ? r_new[w_tail_dec] : '0;
`ifdef AL_PERF_CNT_EN
      if (w_commit && perf_commits != '1) perf_commits <= perf_commits + 32'd1;
      if (w_squash && perf_squashed != '1) perf_squashed <= perf_squashed + 32'd1;
`endif
    end
  end
endmodule

// File: tb/tb_active_list_retire.sv
// tb_active_list_retire: directed retire, fill/wrap, walk-back and reset checks.
module tb_active_list_retire;
  logic       clk = 1'b0;
  logic       rst_n, alloc_valid, alloc_ready, alloc_uses_rw;
  logic [4:0] alloc_arch_rd, alloc_tag, wb_tag, mispredict_tag, commit_arch_rd, recover_arch_rd;
  logic [5:0] alloc_new_phys, alloc_old_phys, commit_new_phys, free_phys, recover_phys;
  logic       wb_valid, mispredict_valid, commit_valid, free_valid, recover_valid, recovering, empty;
  logic [5:0] count;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  active_list_retire dut (
    .clk(clk), .rst_n(rst_n), .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_uses_rw(alloc_uses_rw), .alloc_arch_rd(alloc_arch_rd), .alloc_new_phys(alloc_new_phys),
    .alloc_old_phys(alloc_old_phys), .alloc_tag(alloc_tag), .wb_valid(wb_valid), .wb_tag(wb_tag),
    .mispredict_valid(mispredict_valid), .mispredict_tag(mispredict_tag),
    .commit_valid(commit_valid), .commit_arch_rd(commit_arch_rd), .commit_new_phys(commit_new_phys),
    .free_valid(free_valid), .free_phys(free_phys), .recover_valid(recover_valid),
    .recover_arch_rd(recover_arch_rd), .recover_phys(recover_phys), .recovering(recovering),
    .count(count), .empty(empty)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic alloc(input logic u, input logic [4:0] a, input logic [5:0] n, input logic [5:0] o);
    alloc_valid    = 1'b1;
    alloc_uses_rw  = u;
    alloc_arch_rd  = a;
    alloc_new_phys = n;
    alloc_old_phys = o;
    tick();
    alloc_valid = 1'b0;
  endtask
  task automatic wb(input logic [4:0] t);
    wb_valid = 1'b1;
    wb_tag   = t;
    tick();
    wb_valid = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0; alloc_valid = 1'b0; alloc_uses_rw = 1'b0; alloc_arch_rd = '0;
    alloc_new_phys = '0; alloc_old_phys = '0; wb_valid = 1'b0; wb_tag = '0;
    mispredict_valid = 1'b0; mispredict_tag = '0;
    tick();
    tick();
    chk("rst_ready", alloc_ready, 0);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_commit", commit_valid, 0);
    chk("rst_recovering", recovering, 0);
    rst_n = 1'b1;
    tick();
    chk("run_ready", alloc_ready, 1);
    for (int i = 0; i < 3; i++) begin
      chk("a_tag", alloc_tag, i);
      alloc(1'b1, 5'(i + 1), 6'(32 + i), 6'(i + 1));
    end
    chk("a_count", count, 3);
    wb(5'd1);
    chk("a_wb1_nocommit", commit_valid, 0);
    wb(5'd0);
    chk("a_wb0_nocommit", commit_valid, 0);
    wb(5'd2);
    chk("a_c0_valid", commit_valid, 1);
    chk("a_c0_arch", commit_arch_rd, 1);
    chk("a_c0_new", commit_new_phys, 32);
    chk("a_c0_free", free_phys, 1);
    chk("a_c0_freev", free_valid, 1);
    tick();
    chk("a_c1_arch", commit_arch_rd, 2);
    chk("a_c1_free", free_phys, 2);
    tick();
    chk("a_c2_arch", commit_arch_rd, 3);
    chk("a_c2_new", commit_new_phys, 34);
    chk("a_c2_free", free_phys, 3);
    tick();
    chk("a_idle_commit", commit_valid, 0);
    chk("a_empty", empty, 1);
    for (int i = 0; i < 32; i++) begin
      chk("b_ready", alloc_ready, 1);
      chk("b_tag", alloc_tag, (i + 3) % 32);
      alloc(1'b1, 5'(i), 6'(32 + i), 6'(i + 1));
    end
    chk("b_full_count", count, 32);
    chk("b_full_ready", alloc_ready, 0);
    chk("b_full_tag", alloc_tag, 3);
    wb(5'd3);
    chk("b_wb_ready", alloc_ready, 0);
    chk("b_wb_nocommit", commit_valid, 0);
    tick();
    chk("b_ready_back", alloc_ready, 1);
    chk("b_count", count, 31);
    chk("b_commit", commit_valid, 1);
    chk("b_commit_new", commit_new_phys, 32);
    chk("b_free", free_phys, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("c_reset_count", count, 0);
    for (int i = 0; i < 5; i++) begin
      chk("c_tag", alloc_tag, i);
      alloc(1'b1, 5'(10 + i), 6'(40 + i), 6'(20 + i));
    end
    mispredict_valid = 1'b1;
    mispredict_tag   = 5'd1;
    tick();
    mispredict_valid = 1'b0;
    chk("c_rec0", recovering, 1);
    chk("c_rec0_rv", recover_valid, 0);
    chk("c_rec0_ready", alloc_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("c_rv", recover_valid, 1);
      chk("c_rarch", recover_arch_rd, 14 - i);
      chk("c_rphys", recover_phys, 24 - i);
      chk("c_fv", free_valid, 1);
      chk("c_fphys", free_phys, 44 - i);
      chk("c_recovering", recovering, i < 2 ? 1 : 0);
    end
    chk("c_count", count, 2);
    chk("c_tail", alloc_tag, 2);
    tick();
    chk("c_rv_off", recover_valid, 0);
    chk("c_fv_off", free_valid, 0);
    mispredict_valid = 1'b1;
    mispredict_tag   = 5'd1;
    tick();
    mispredict_valid = 1'b0;
    chk("d_recovering", recovering, 0);
    chk("d_ready", alloc_ready, 1);
    tick();
    chk("d_rv", recover_valid, 0);
    chk("d_count", count, 2);
    wb(5'd3);
    chk("e_stale_count", count, 2);
    alloc(1'b0, 5'd5, 6'd50, 6'd30);
    alloc(1'b1, 5'd6, 6'd51, 6'd31);
    chk("e_count4", count, 4);
    wb(5'd0);
    wb(5'd1);
    chk("e_c0_arch", commit_arch_rd, 10);
    chk("e_c0_free", free_phys, 20);
    wb(5'd2);
    chk("e_c1_arch", commit_arch_rd, 11);
    chk("e_c1_new", commit_new_phys, 41);
    tick();
    chk("e_silent_cv", commit_valid, 0);
    chk("e_silent_fv", free_valid, 0);
    chk("e_silent_count", count, 1);
    tick();
    chk("e_stale_nocommit", commit_valid, 0);
    chk("e_stale_count1", count, 1);
    for (int i = 0; i < 3; i++) alloc(1'b1, 5'(20 + i), 6'(55 + i), 6'(60 + i));
    mispredict_valid = 1'b1;
    mispredict_tag   = 5'd3;
    tick();
    mispredict_valid = 1'b0;
    chk("f_recovering", recovering, 1);
    tick();
    chk("f_rv", recover_valid, 1);
    chk("f_rarch", recover_arch_rd, 22);
    chk("f_rphys", recover_phys, 62);
    chk("f_fphys", free_phys, 57);
    rst_n = 1'b0;
    tick();
    chk("f_count", count, 0);
    chk("f_recovering_off", recovering, 0);
    chk("f_rv_off", recover_valid, 0);
    chk("f_fv_off", free_valid, 0);
    chk("f_cv_off", commit_valid, 0);
    chk("f_empty", empty, 1);
    chk("f_ready_rst", alloc_ready, 0);
    rst_n = 1'b1;
    tick();
    chk("f_ready", alloc_ready, 1);
    chk("f_tag", alloc_tag, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
